// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble/redirect scheduler for the 5-stage F/D/E/M/W pipeline.
// Merges data-bus, mul/div, load-use and instruction-bus hazards into per-stage
// stall/bubble controls. It also defers taken-branch redirects while fetch is stalled.
// Optional build macro PIPE_CTRL_PERF_EN adds the stall_cycles/redirect_cnt counters.
//
// md FSM states
//   state   | meaning
//   MD_IDLE | no mul/div in flight; a start may be accepted
//   MD_RUN  | counting down; done when cnt reaches 0
//   MD_HOLD | result ready, waiting for E to advance past a data-bus stall
module pipe_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_busy,
  input  logic        dbus_busy,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        f_stall,
  output logic        d_stall,
  output logic        e_stall,
  output logic        m_stall,
  output logic        d_bubble,
  output logic        e_bubble,
  output logic        m_bubble,
  output logic        w_bubble,
  output logic        redirect_fire,
  output logic        md_busy,
  output logic        md_done
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_HOLD = 2'd2
  } md_state_e;

  md_state_e        md_state_q, md_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect_pend_q, redirect_pend_d;
  logic             md_busy_c, md_done_c, md_stall;
  logic             br_ok;
  int               n_sel;

  // mul/div sequencing: next state, counter and busy/done flags
  always_comb begin
    md_state_d = md_state_q;
    cnt_d      = cnt_q;
    md_busy_c  = 1'b0;
    md_done_c  = 1'b0;
    n_sel      = md_is_div ? DIV_CYCLES : MUL_CYCLES;
    unique case (md_state_q)
      MD_IDLE: begin
        // A start under a data-bus stall waits; E holds the instruction.
        if (md_start && !dbus_busy) begin
          md_busy_c = 1'b1;
          if (n_sel == 1) begin
            md_done_c = 1'b1;
          end else begin
            cnt_d      = CNT_W'(n_sel - 2);
            md_state_d = MD_RUN;
          end
        end
      end
      MD_RUN: begin
        md_busy_c = 1'b1;
        if (cnt_q == '0) begin
          md_done_c  = 1'b1;
          md_state_d = dbus_busy ? MD_HOLD : MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_HOLD: begin
        md_busy_c = 1'b1;
        md_done_c = 1'b1;
        if (!dbus_busy) md_state_d = MD_IDLE;
      end
      default: md_state_d = MD_IDLE;
    endcase
  end

  // priority-ordered stall/bubble generation; everything forced low in reset
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    e_stall  = 1'b0;
    m_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_bubble = 1'b0;
    md_stall = md_busy_c & ~md_done_c;
    if (reset) begin
      f_stall = 1'b0;
    end else if (dbus_busy) begin
      {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
      w_bubble = 1'b1;
    end else if (md_stall) begin
      {f_stall, d_stall, e_stall} = 3'b111;
      m_bubble = 1'b1;
    end else if (load_use) begin
      {f_stall, d_stall} = 2'b11;
      e_bubble = 1'b1;
    end else if (ibus_busy) begin
      f_stall  = 1'b1;
      d_bubble = 1'b1;
    end
  end

  // redirect: fire now if fetch moves, otherwise remember it until fetch moves
  always_comb begin
    md_busy         = ~reset & md_busy_c;
    md_done         = ~reset & md_done_c;
    br_ok           = branch_taken & ~d_stall & ~redirect_pend_q;
    redirect_fire   = ~reset & ~f_stall & (redirect_pend_q | br_ok);
    redirect_pend_d = f_stall & (redirect_pend_q | br_ok);
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state_q      <= MD_IDLE;
      cnt_q           <= '0;
      redirect_pend_q <= 1'b0;
    end else begin
      md_state_q      <= md_state_d;
      cnt_q           <= cnt_d;
      redirect_pend_q <= redirect_pend_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, redirect_cnt_q;

  // free-running performance counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_q + {31'd0, f_stall};
      redirect_cnt_q <= redirect_cnt_q + {31'd0, redirect_fire};
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios followed by random stimulus,
// with expected outputs from a cycle-count reference model.
module tb_pipe_ctrl;

  localparam int MUL_N = 3;
  localparam int DIV_N = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ibus_busy = 1'b0, dbus_busy = 1'b0, load_use = 1'b0;
  logic branch_taken = 1'b0, md_start = 1'b0, md_is_div = 1'b0;
  logic f_stall, d_stall, e_stall, m_stall;
  logic d_bubble, e_bubble, m_bubble, w_bubble;
  logic redirect_fire, md_busy, md_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, redirect_cnt;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .ibus_busy(ibus_busy), .dbus_busy(dbus_busy), .load_use(load_use),
    .branch_taken(branch_taken), .md_start(md_start), .md_is_div(md_is_div),
    .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
    .d_bubble(d_bubble), .e_bubble(e_bubble), .m_bubble(m_bubble), .w_bubble(w_bubble),
    .redirect_fire(redirect_fire), .md_busy(md_busy), .md_done(md_done)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .redirect_cnt(redirect_cnt)
`endif
  );

  typedef struct packed {
    logic [10:0] v;
    logic [31:0] sc;
    logic [31:0] rc;
    logic        cnt_ok;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // reference model state: mul/div in flight, cycles left until done, pending redirect
  bit          m_active = 0;
  int          m_rem    = 0;
  bit          m_pend   = 0;
  logic [31:0] m_sc     = 0;
  logic [31:0] m_rc     = 0;
  bit          m_cnt_ok = 0;

  task automatic apply(input bit r, input bit db, input bit ms, input bit dv,
                       input bit lu, input bit ib, input bit br);
    bit fs, ds, es, mst, dbb, ebb, mbb, wbb, fire, busy, done, take;
    int rem_now;
    exp_t e;
    reset = r; dbus_busy = db; md_start = ms; md_is_div = dv;
    load_use = lu; ibus_busy = ib; branch_taken = br;
    {fs, ds, es, mst, dbb, ebb, mbb, wbb, fire, busy, done} = '0;
    rem_now = 0;
    if (!r) begin
      if (m_active) begin
        busy = 1; rem_now = m_rem;
      end else if (ms && !db) begin
        busy = 1; rem_now = (dv ? DIV_N : MUL_N) - 1;
      end
      done = busy && (rem_now == 0);
      if (db)                begin fs = 1; ds = 1; es = 1; mst = 1; wbb = 1; end
      else if (busy && !done) begin fs = 1; ds = 1; es = 1; mbb = 1; end
      else if (lu)            begin fs = 1; ds = 1; ebb = 1; end
      else if (ib)            begin fs = 1; dbb = 1; end
      take = m_pend || (br && !ds);
      fire = take && !fs;
      m_pend = take && fs;
      if (busy) begin
        if (done) begin m_active = db; m_rem = 0; end
        else      begin m_active = 1;  m_rem = rem_now - 1; end
      end
    end else begin
      m_active = 0; m_rem = 0; m_pend = 0;
    end
    e.v      = {fs, ds, es, mst, dbb, ebb, mbb, wbb, fire, busy, done};
    e.sc     = m_sc;
    e.rc     = m_rc;
    e.cnt_ok = m_cnt_ok;
    e.cyc    = cyc;
    exp_q.push_back(e);
    if (r) begin
      m_sc = 0; m_rc = 0; m_cnt_ok = 1;
    end else begin
      m_sc = m_sc + 32'(fs);
      m_rc = m_rc + 32'(fire);
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [10:0] act;
      e = exp_q.pop_front();
      act = {f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, m_bubble, w_bubble,
             redirect_fire, md_busy, md_done};
      n_vec++;
      if (act !== e.v) begin
        n_err++;
        $display("FAIL outs cyc=%0d got=%b want=%b (fsdsesms_dbebmbwb_fire_busy_done)",
                 e.cyc, act, e.v);
      end
`ifdef PIPE_CTRL_PERF_EN
      if (e.cnt_ok) begin
        n_vec++;
        if (stall_cycles !== e.sc || redirect_cnt !== e.rc) begin
          n_err++;
          $display("FAIL perf cyc=%0d got sc=%0d rc=%0d want sc=%0d rc=%0d",
                   e.cyc, stall_cycles, redirect_cnt, e.sc, e.rc);
        end
      end
`endif
    end
  end

  initial begin
    @(posedge clk); #1;
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 0, 1, 1, 1);
    idle(2);
    // load-use single cycle
    apply(0, 0, 0, 0, 1, 0, 0);
    idle(1);
    // data-bus stall masks a load-use bubble
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 1, 0, 0);
    idle(1);
    // branch under fetch stall: fires when ibus drops
    apply(0, 0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // multiply: start held while E is stalled
    for (int i = 0; i < MUL_N; i++) apply(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    // divide with data-bus stall across the done cycle and two more
    apply(0, 0, 1, 1, 0, 0, 0);
    idle(DIV_N - 2);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 0, 0, 0);
    idle(3);
    // reset during a divide with a redirect pending
    apply(0, 0, 0, 0, 0, 1, 1);
    apply(0, 0, 1, 1, 0, 1, 0);
    idle(4);
    apply(1, 0, 0, 0, 0, 0, 0);
    idle(4);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0));
    end
    idle(2);
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
